// File: rtl/spi_master_if.sv
// Host-side and SPI-side signal bundle for spi_master.
interface spi_master_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] len;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, addr, len, tx_data, miso,
    output tx_ack, rx_data, rx_valid, busy, done, sclk, cs_n, mosi
  );

  modport slave (
    output start, addr, len, tx_data, miso,
    input  tx_ack, rx_data, rx_valid, busy, done, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode 0 master: sends an address byte followed by len data bytes,
// MSB first, returning the bytes read back during the data phase.
// CLK_DIV is legal in 2..255; CS_SETUP and CS_HOLD are legal in 1..256.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [8:0] byte_q, byte_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sh_tx_q, sh_tx_d;
  logic [7:0] sh_rx_q, sh_rx_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tx_ack_q, tx_ack_d;
  logic       rx_valid_q, rx_valid_d;

  // State register and all datapath registers; reset forces the idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      len_q      <= '0;
      sh_tx_q    <= '0;
      sh_rx_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      sh_tx_q    <= sh_tx_d;
      sh_rx_q    <= sh_rx_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state logic: chip-select setup, bit/byte sequencing, chip-select hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    len_d      = len_q;
    sh_tx_d    = sh_tx_q;
    sh_rx_d    = sh_rx_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;

    // The next data byte is taken from tx_data during the tx_ack cycle itself.
    if (tx_ack_q) sh_tx_d = bus.tx_data;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sh_tx_d = bus.addr;
          len_d   = bus.len;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            sh_rx_d = {sh_rx_q[6:0], bus.miso};
          end else if (bit_q == 3'd7) begin
            bit_d = '0;
            if (byte_q != '0) begin
              rx_data_d  = sh_rx_q;
              rx_valid_d = 1'b1;
            end
            if (byte_q == {1'b0, len_q}) begin
              state_d = HOLD;
            end else begin
              byte_d   = byte_q + 9'd1;
              tx_ack_d = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            sh_tx_d = {sh_tx_q[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_ack   = tx_ack_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  // While tx_ack is high the shift register still holds the old byte, so the
  // new MSB is forwarded straight from tx_data for that one cycle.
  assign bus.mosi     = ~cs_n_q & (tx_ack_q ? bus.tx_data[7] : sh_tx_q[7]);

endmodule
